// File: rtl/text_buffer_arbiter_if.sv
// Writer/reader bus of the text screen buffer: two byte-write requesters with
// grant handshakes, a clear request, and the text engine's read port.
interface text_buffer_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        data0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        data1;
  logic              gnt1;
  logic              clearReq;
  logic [ADDR_W-1:0] charAddress;
  logic [7:0]        charOut;
  logic              busy;

  modport master (
    output req0, addr0, data0, req1, addr1, data1, clearReq, charAddress,
    input  gnt0, gnt1, charOut, busy
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, clearReq, charAddress,
    output gnt0, gnt1, charOut, busy
  );
endinterface

// File: rtl/text_buffer_arbiter.sv
// 64-character screen buffer: round-robin arbitration of two byte writers,
// full-buffer clear after reset and on demand, and an unstalled registered read port.
module text_buffer_arbiter #(
  parameter int         NUM_CHARS  = 64,
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                resetN,
  text_buffer_arbiter_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(NUM_CHARS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_CHARS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rr_q, rr_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;
  logic [7:0]        char_out_q, char_out_d;

  logic [7:0]        mem [NUM_CHARS];

  logic              elig0, elig1;
  logic              win0, win1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Only matters when NUM_CHARS is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rr_d       = rr_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    busy_d     = busy_q;
    char_out_d = mem[bus.charAddress];
    win0       = 1'b0;
    win1       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = clr_ptr_q;
    wr_data    = CLEAR_CHAR;
    // A requester still seeing its grant is not eligible, so a held req
    // cannot write the same byte twice.
    elig0      = bus.req0 & ~gnt0_q;
    elig1      = bus.req1 & ~gnt1_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
          busy_d    = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clearReq) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else begin
          // rr_q == 0 favours requester 0 when both are eligible.
          win0   = elig0 & (~elig1 | ~rr_q);
          win1   = elig1 & (~elig0 | rr_q);
          gnt0_d = win0;
          gnt1_d = win1;
          if (win0) begin
            rr_d    = 1'b1;
            wr_addr = bus.addr0;
            wr_data = bus.data0;
            wr_en   = in_range(bus.addr0);
          end else if (win1) begin
            rr_d    = 1'b0;
            wr_addr = bus.addr1;
            wr_data = bus.data1;
            wr_en   = in_range(bus.addr1);
          end
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      rr_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b1;
      char_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rr_q       <= rr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      busy_q     <= busy_d;
      char_out_q <= char_out_d;
    end
  end

  // Storage is left unreset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.charOut = char_out_q;

endmodule
